wdg_wb_arb: RTL and testbench

- Round-robin Wishbone (pipelined, stall-capable) arbiter that shares the single watchdog register slave port between NUM_REQ bus masters, e.g. two harts or a hart plus a debug module.
- Sits between the masters and wdg_top's Wishbone slave port.
- Locks the grant for a whole bus cycle (cyc high) and tracks outstanding transfers.
- Force-releases a master that holds cyc while idle, so a hung requester cannot block watchdog servicing.

---
 rtl/wdg_wb_arb_pkg.sv | 21 ++
 rtl/wdg_rr_picker.sv | 36 +++
 rtl/wdg_wb_arb.sv | 194 +++++++++++++++++++
 tb/tb_wdg_wb_arb.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdg_wb_arb_pkg.sv
// rtl/wdg_wb_arb_pkg.sv - shared state encoding and sizing helper for the watchdog bus arbiter
package wdg_wb_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wdg_rr_picker.sv
// rtl/wdg_rr_picker.sv - combinational round-robin select starting just after the last winner
module wdg_rr_picker
    import wdg_wb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any
);

    // Two passes: indices above last first, then wrap around to the rest.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (IDX_W'(i) > last)) begin
                winner[i]  = 1'b1;
                winner_idx = IDX_W'(i);
                any        = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (IDX_W'(i) <= last)) begin
                winner[i]  = 1'b1;
                winner_idx = IDX_W'(i);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wdg_wb_arb.sv
// rtl/wdg_wb_arb.sv - round-robin pipelined Wishbone arbiter in front of the watchdog slave port
module wdg_wb_arb
    import wdg_wb_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int HOLD_LIMIT      = 64
) (
    input  logic                          clk,
    input  logic                          res_n,
    input  logic [NUM_REQ-1:0]            i_m_cyc,
    input  logic [NUM_REQ-1:0]            i_m_stb,
    input  logic [NUM_REQ-1:0]            i_m_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_m_adr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_m_dat,
    input  logic [NUM_REQ*4-1:0]          i_m_sel,
    output logic [NUM_REQ-1:0]            o_m_stall,
    output logic [NUM_REQ-1:0]            o_m_ack,
    output logic [NUM_REQ-1:0]            o_m_err,
    output logic [NUM_REQ-1:0]            o_m_rty,
    output logic [DATA_WIDTH-1:0]         o_m_dat,
    output logic                          o_s_cyc,
    output logic                          o_s_stb,
    output logic                          o_s_we,
    output logic [ADDR_WIDTH-1:0]         o_s_adr,
    output logic [DATA_WIDTH-1:0]         o_s_dat,
    output logic [3:0]                    o_s_sel,
    input  logic                          i_s_stall,
    input  logic                          i_s_ack,
    input  logic                          i_s_err,
    input  logic                          i_s_rty,
    input  logic [DATA_WIDTH-1:0]         i_s_dat,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_hold_viol
);

    localparam int IDX_W  = clog2(NUM_REQ);
    localparam int OUT_W  = clog2(MAX_OUTSTANDING + 1);
    localparam int HOLD_W = clog2(HOLD_LIMIT + 1);
    localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LIMIT - 1);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [OUT_W-1:0]    outst_q, outst_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [NUM_REQ-1:0]    pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;

    logic                  own_cyc, own_stb, own_we;
    logic [ADDR_WIDTH-1:0] own_adr;
    logic [DATA_WIDTH-1:0] own_dat;
    logic [3:0]            own_sel;
    logic                  busy, full, accept, idle_cycle, hold_hit, release_now, resp;

    wdg_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (i_m_cyc),
        .last       (last_q),
        .winner     (pick_oh),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == IDX_W'(i)) begin
                own_cyc = i_m_cyc[i];
                own_stb = i_m_stb[i];
                own_we  = i_m_we[i];
                own_adr = i_m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
                own_dat = i_m_dat[i*DATA_WIDTH +: DATA_WIDTH];
                own_sel = i_m_sel[i*4 +: 4];
            end
        end
    end

    // A cycle counts as idle hold when the owner keeps cyc up with nothing in flight and nothing accepted.
    assign busy        = (state_q == ST_BUSY);
    assign full        = (outst_q == OUT_MAX);
    assign accept      = busy & own_cyc & own_stb & ~full & ~i_s_stall;
    assign idle_cycle  = busy & own_cyc & (outst_q == '0) & ~accept;
    assign hold_hit    = idle_cycle & (hold_q == HOLD_LAST);
    assign release_now = busy & (~own_cyc | hold_hit);
    assign resp        = i_s_ack | i_s_err | i_s_rty;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            outst_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            outst_q <= outst_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        outst_d = outst_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                outst_d = '0;
                hold_d  = '0;
                if (pick_any) begin
                    state_d = ST_BUSY;
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    last_d  = pick_idx;
                end
            end
            ST_BUSY: begin
                if (release_now) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    outst_d = '0;
                    hold_d  = '0;
                end else begin
                    if (accept && !resp) begin
                        outst_d = outst_q + OUT_W'(1);
                    end else if (!accept && resp && (outst_q != '0)) begin
                        outst_d = outst_q - OUT_W'(1);
                    end
                    if (accept) begin
                        hold_d = '0;
                    end else if (idle_cycle) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_s_cyc     = 1'b0;
        o_s_stb     = 1'b0;
        o_s_we      = 1'b0;
        o_s_adr     = '0;
        o_s_dat     = '0;
        o_s_sel     = '0;
        o_m_stall   = '1;
        o_m_ack     = '0;
        o_m_err     = '0;
        o_m_rty     = '0;
        o_hold_viol = 1'b0;
        if (busy) begin
            o_s_cyc     = own_cyc & ~hold_hit;
            o_s_stb     = own_cyc & own_stb & ~full & ~hold_hit;
            o_s_we      = own_we;
            o_s_adr     = own_adr;
            o_s_dat     = own_dat;
            o_s_sel     = own_sel;
            o_hold_viol = hold_hit;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gidx_q == IDX_W'(i)) begin
                    o_m_stall[i] = i_s_stall | full;
                    o_m_ack[i]   = i_s_ack;
                    o_m_err[i]   = i_s_err;
                    o_m_rty[i]   = i_s_rty;
                end
            end
        end
    end

    assign o_grant = grant_q;
    assign o_m_dat = i_s_dat;

endmodule

// File: tb/tb_wdg_wb_arb.sv
// tb/tb_wdg_wb_arb.sv - directed and randomized bench for wdg_wb_arb with a behavioural reference model
module tb_wdg_wb_arb;

    localparam int N    = 2;
    localparam int AW   = 2;
    localparam int DW   = 32;
    localparam int MAXO = 4;
    localparam int HOLD = 64;

    logic            clk = 1'b0;
    logic            res_n = 1'b0;
    logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N*AW-1:0] m_adr = '0;
    logic [N*DW-1:0] m_dat = '0;
    logic [N*4-1:0]  m_sel = '0;
    logic            s_stall = 1'b0, s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
    logic [DW-1:0]   s_dat = '0;

    logic [N-1:0]    stall, ack, err, rty, grant;
    logic [DW-1:0]   m_rdat, s_wdat;
    logic            s_cyc, s_stb, s_we, hold_viol;
    logic [AW-1:0]   s_adr;
    logic [3:0]      s_sel;

    int checks = 0;
    int failures = 0;

    wdg_wb_arb #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .HOLD_LIMIT(HOLD)
    ) dut (
        .clk(clk), .res_n(res_n),
        .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we), .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
        .o_m_stall(stall), .o_m_ack(ack), .o_m_err(err), .o_m_rty(rty), .o_m_dat(m_rdat),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr), .o_s_dat(s_wdat), .o_s_sel(s_sel),
        .i_s_stall(s_stall), .i_s_ack(s_ack), .i_s_err(s_err), .i_s_rty(s_rty), .i_s_dat(s_dat),
        .o_grant(grant), .o_hold_viol(hold_viol)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res_n = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        tick();
        tick();
        res_n = 1'b1;
    endtask

    // Reference model: owner (-1 when nobody holds the port), last winner, in-flight count, idle-hold run.
    int md_owner = -1, md_last = N - 1, md_outst = 0, md_idle = 0;
    int pd_owner = -1, pd_last = N - 1, pd_outst = 0, pd_idle = 0;

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            md_owner <= -1; md_last <= N - 1; md_outst <= 0; md_idle <= 0;
        end else begin
            md_owner <= pd_owner; md_last <= pd_last; md_outst <= pd_outst; md_idle <= pd_idle;
        end
    end

    always @(negedge clk) begin : cmp_blk
        int o, n_owner, n_last, n_outst, n_idle, idx;
        logic c, full, took, idle_c, hv, scyc, sstb, any_resp;
        logic [N-1:0] e_stall, e_ack, e_err, e_rty, e_grant;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [3:0] e_sel;
        logic e_we;
        o = md_owner;
        e_stall = '1; e_ack = '0; e_err = '0; e_rty = '0; e_grant = '0;
        e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0;
        c = 1'b0; full = 1'b0; took = 1'b0; idle_c = 1'b0; hv = 1'b0; scyc = 1'b0; sstb = 1'b0;
        any_resp = s_ack | s_err | s_rty;
        if (o >= 0) begin
            c      = m_cyc[o];
            full   = (md_outst == MAXO);
            took   = c && m_stb[o] && !full && !s_stall;
            idle_c = c && (md_outst == 0) && !took;
            hv     = idle_c && (md_idle + 1 == HOLD);
            scyc   = c && !hv;
            sstb   = scyc && m_stb[o] && !full;
            e_grant[o] = 1'b1;
            e_we   = m_we[o];
            e_adr  = m_adr[o*AW +: AW];
            e_dat  = m_dat[o*DW +: DW];
            e_sel  = m_sel[o*4 +: 4];
            e_stall[o] = s_stall || full;
            e_ack[o] = s_ack; e_err[o] = s_err; e_rty[o] = s_rty;
        end
        chk("grant", grant, e_grant);
        chk("s_cyc", s_cyc, scyc);
        chk("s_stb", s_stb, sstb);
        chk("s_we", s_we, e_we);
        chk("s_adr", s_adr, e_adr);
        chk("s_dat", s_wdat, e_dat);
        chk("s_sel", s_sel, e_sel);
        chk("m_stall", stall, e_stall);
        chk("m_resp", {ack, err, rty}, {e_ack, e_err, e_rty});
        chk("m_dat", m_rdat, s_dat);
        chk("hold_viol", hold_viol, hv);

        n_owner = md_owner; n_last = md_last; n_outst = md_outst; n_idle = md_idle;
        if (!res_n) begin
            n_owner = -1; n_last = N - 1; n_outst = 0; n_idle = 0;
        end else if (o < 0) begin
            for (int k = 1; k <= N; k++) begin
                idx = (md_last + k) % N;
                if (n_owner < 0 && m_cyc[idx]) n_owner = idx;
            end
            if (n_owner >= 0) n_last = n_owner;
            n_outst = 0; n_idle = 0;
        end else if (!scyc) begin
            n_owner = -1; n_outst = 0; n_idle = 0;
        end else begin
            n_outst = md_outst + (took ? 1 : 0) - (any_resp ? 1 : 0);
            if (n_outst < 0) n_outst = 0;
            n_idle = took ? 0 : (idle_c ? md_idle + 1 : md_idle);
        end
        pd_owner <= n_owner; pd_last <= n_last; pd_outst <= n_outst; pd_idle <= n_idle;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int issued, acks, spend, viol_at, pulses, r;
        logic ack_en, fullseen;
        logic [1:0] cur;
        logic [1:0] alt_exp [3];
        alt_exp = '{2'b01, 2'b10, 2'b01};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_stall", stall, 2'b11);
        chk("rst_scyc", s_cyc, 1'b0);
        chk("rst_viol", hold_viol, 1'b0);
        res_n = 1'b1;

        // single master write
        tick();
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; m_adr = 4'b0001;
        m_dat = {32'h0, 32'h0000_0A01}; m_sel = 8'h0F;
        #1;
        chk("t2_idle_grant", grant, 2'b00);
        chk("t2_idle_stb", s_stb, 1'b0);
        tick();
        #1;
        chk("t2_grant", grant, 2'b01);
        chk("t2_stb", s_stb, 1'b1);
        chk("t2_adr", s_adr, 2'd1);
        chk("t2_dat", s_wdat, 32'h0000_0A01);
        tick();
        m_stb = 2'b00; s_ack = 1'b1;
        #1;
        chk("t2_ack", ack, 2'b01);
        tick();
        s_ack = 1'b0; m_cyc = 2'b00; m_we = 2'b00;
        #1;
        chk("t2_release_cyc", s_cyc, 1'b0);
        tick();
        #1;
        chk("t2_idle_after", grant, 2'b00);

        // contention and alternation
        do_reset();
        m_cyc = 2'b11;
        tick();
        #1;
        chk("t3_first", grant, 2'b01);
        m_cyc = 2'b10;
        #1;
        chk("t3_drop_cyc", s_cyc, 1'b0);
        tick();
        #1;
        chk("t3_idle", grant, 2'b00);
        tick();
        #1;
        chk("t3_handover", grant, 2'b10);
        cur = 2'b10;
        for (int k = 0; k < 3; k++) begin
            m_cyc = ~cur;
            tick();
            m_cyc = 2'b11;
            tick();
            #1;
            chk("t3_alternate", grant, alt_exp[k]);
            cur = alt_exp[k];
        end
        m_cyc = 2'b00;
        tick();
        tick();

        // pipelining against the outstanding limit
        m_cyc = 2'b01; m_stb = 2'b00;
        issued = 0; acks = 0; spend = 0; ack_en = 1'b0; fullseen = 1'b0;
        for (int n = 0; n < 80 && acks < 6; n++) begin
            tick();
            m_stb[0] = (issued < 6);
            s_ack = ack_en && (spend > 0);
            #1;
            if (spend == MAXO && !fullseen) begin
                chk("t4_full_stb", s_stb, 1'b0);
                chk("t4_full_stall", stall[0], 1'b1);
                fullseen = 1'b1;
                ack_en = 1'b1;
            end
            if (s_stb && !s_stall) begin spend++; issued++; end
            if (s_ack) begin spend--; acks++; end
        end
        chk("t4_acks", acks, 6);
        chk("t4_issued", issued, 6);
        chk("t4_full_seen", fullseen, 1'b1);
        tick();
        m_stb = 2'b00; s_ack = 1'b0; m_cyc = 2'b00;
        tick();
        tick();

        // slave stall
        m_cyc = 2'b01; m_stb = 2'b01; s_stall = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_stalled", stall, 2'b11);
            chk("t5_stb_held", s_stb, 1'b1);
            tick();
        end
        s_stall = 1'b0;
        #1;
        chk("t5_unstalled", stall, 2'b10);
        tick();
        m_stb = 2'b00; s_ack = 1'b1;
        #1;
        chk("t5_ack", ack, 2'b01);
        tick();
        s_ack = 1'b0; m_cyc = 2'b00;
        tick();
        tick();

        // hold timeout
        do_reset();
        m_cyc = 2'b10;
        tick();
        #1;
        chk("t6_owner_m1", grant, 2'b10);
        m_cyc = 2'b11;
        viol_at = -1; pulses = 0;
        for (int n = 0; n < 80; n++) begin
            if (n > 0) tick();
            #1;
            if (hold_viol) begin
                pulses++;
                viol_at = n;
                break;
            end
        end
        chk("t6_viol_cycle", viol_at, 63);
        chk("t6_viol_grant", grant, 2'b10);
        chk("t6_viol_scyc", s_cyc, 1'b0);
        tick();
        #1;
        chk("t6_idle", grant, 2'b00);
        tick();
        #1;
        chk("t6_m0_wins", grant, 2'b01);
        for (int n = 0; n < 10; n++) begin
            tick();
            #1;
            if (hold_viol) pulses++;
        end
        chk("t6_pulses", pulses, 1);
        m_cyc = 2'b00;
        tick();
        tick();

        // asynchronous reset with two strobes in flight
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        tick();
        tick();
        m_stb = 2'b00;
        #1;
        res_n = 1'b0;
        #1;
        chk("t7_grant", grant, 2'b00);
        chk("t7_scyc", s_cyc, 1'b0);
        chk("t7_stall", stall, 2'b11);
        tick();
        tick();
        res_n = 1'b1;
        tick();
        #1;
        chk("t7_m0_first", grant, 2'b01);
        m_cyc = 2'b00;
        tick();
        tick();

        // randomized traffic: busy phase, then a sparse phase that reaches the hold limit
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                tick();
                for (int k = 0; k < N; k++) begin
                    if ($urandom_range(0, (ph == 0) ? 15 : 127) == 0) m_cyc[k] = ~m_cyc[k];
                    m_stb[k] = m_cyc[k] & ($urandom_range(0, (ph == 0) ? 1 : 40) == 0);
                    m_we[k] = 1'($urandom_range(0, 1));
                end
                m_adr = N*AW'($urandom);
                m_dat = {$urandom, $urandom};
                m_sel = N*4'($urandom);
                s_stall = ($urandom_range(0, 3) == 0);
                r = $urandom_range(0, 5);
                s_ack = (r == 0); s_err = (r == 1); s_rty = (r == 2);
                s_dat = $urandom;
            end
        end
        tick();
        m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_stall = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
